// File: rtl/snake_grid_buffer.sv
// snake_grid_buffer: 15x15 2-bit cell store with clear sweep, write port, query/display reads and snake/food counters
module snake_grid_buffer #(
    parameter int GRID_W = 15,
    parameter int GRID_H = 15,
    parameter int CELLS  = GRID_W * GRID_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    output logic       busy,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_data,
    output logic       wr_err,
    input  logic [3:0] q_x,
    input  logic [3:0] q_y,
    output logic [1:0] q_data,
    input  logic [3:0] XLocation,
    input  logic [3:0] YLocation,
    output logic [1:0] data,
    output logic [7:0] snake_count,
    output logic [7:0] food_count
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    function automatic logic [7:0] lin(input logic [3:0] x, input logic [3:0] y);
        return 8'(y) * 8'(GRID_W) + 8'(x);
    endfunction

    function automatic logic inr(input logic [3:0] x, input logic [3:0] y);
        return (32'(x) < GRID_W) && (32'(y) < GRID_H);
    endfunction

    logic [1:0] mem [CELLS];
    logic [0:0] state;
    logic [7:0] clr_idx;
    logic       wr_fire, wr_in;
    logic [7:0] wi;
    logic [1:0] old;

    assign busy     = state == CLEAR;
    assign wr_ready = state == IDLE;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_in    = inr(wr_x, wr_y);
    assign wi       = lin(wr_x, wr_y);
    assign old      = wr_in ? mem[wi] : 2'b00;
    assign q_data   = !inr(q_x, q_y) ? 2'b11 : busy ? 2'b00 : mem[lin(q_x, q_y)];
    assign data     = (busy || !inr(XLocation, YLocation)) ? 2'b00 : mem[lin(XLocation, YLocation)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            wr_err      <= 1'b0;
            snake_count <= '0;
            food_count  <= '0;
        end else begin
            wr_err <= wr_fire && !wr_in;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 8'd1;
                if (clr_idx == 8'(CELLS - 1)) state <= IDLE;
            end else if (clear_req) begin
                state       <= CLEAR;
                clr_idx     <= '0;
                snake_count <= '0;
                food_count  <= '0;
            end else if (wr_fire && wr_in) begin
                // old and new of the same code cancel, so no special case is needed
                snake_count <= snake_count + 8'(wr_data == 2'b10) - 8'(old == 2'b10);
                food_count  <= food_count + 8'(wr_data == 2'b01) - 8'(old == 2'b01);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_idx] <= 2'b00;
        else if (wr_fire && wr_in) mem[wi] <= wr_data;
    end
endmodule

// File: tb/tb_snake_grid_buffer.sv
// tb_snake_grid_buffer: directed self-checking bench for snake_grid_buffer
module tb_snake_grid_buffer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_x = '0, wr_y = '0;
    logic [1:0] wr_data = '0;
    logic       wr_err;
    logic [3:0] q_x = '0, q_y = '0;
    logic [1:0] q_data;
    logic [3:0] XLocation = '0, YLocation = '0;
    logic [1:0] data;
    logic [7:0] snake_count, food_count;

    int errors = 0;
    int checks = 0;

    snake_grid_buffer dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_err(wr_err), .q_x(q_x), .q_y(q_y), .q_data(q_data),
        .XLocation(XLocation), .YLocation(YLocation), .data(data),
        .snake_count(snake_count), .food_count(food_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        wr_valid = 1'b1; wr_x = x; wr_y = y; wr_data = d;
        tick();
        wr_valid = 1'b0;
        #1;
    endtask

    task automatic look(input logic [3:0] x, input logic [3:0] y);
        q_x = x; q_y = y; XLocation = x; YLocation = y;
        #1;
    endtask

    // counts edges until busy drops, flagging any cycle where wr_ready rose or data leaked
    task automatic sweep(output int n, output int leaks);
        n = 0; leaks = 0;
        while (busy && n < 300) begin
            tick();
            n++;
            if (busy && (wr_ready !== 1'b0 || data !== 2'b00)) leaks++;
        end
    endtask

    task automatic all_zero(output int bad);
        bad = 0;
        for (int y = 0; y < 15; y++)
            for (int x = 0; x < 15; x++) begin
                look(4'(x), 4'(y));
                if (data !== 2'b00 || q_data !== 2'b00) bad++;
            end
    endtask

    initial begin
        int n, leaks, bad;
        look(3, 4);
        tick();
        chk("reset_busy", busy, 1);
        chk("reset_ready", wr_ready, 0);
        chk("reset_err", wr_err, 0);
        chk("reset_snake", snake_count, 0);
        chk("reset_food", food_count, 0);
        wr_valid = 1'b1; wr_x = 2; wr_y = 2; wr_data = 2'b10;
        reset = 1'b1;
        sweep(n, leaks);
        wr_valid = 1'b0;
        chk("sweep_len", n, 225);
        chk("sweep_leaks", leaks, 0);
        all_zero(bad);
        chk("all_cells_zero", bad, 0);
        chk("idle_snake0", snake_count, 0);
        chk("idle_food0", food_count, 0);
        chk("idle_ready", wr_ready, 1);

        wr(5, 7, 2'b10);
        wr(6, 7, 2'b10);
        wr(14, 14, 2'b01);
        look(5, 7);
        chk("q_5_7", q_data, 2'b10);
        look(14, 14);
        chk("data_14_14", data, 2'b01);
        chk("snake2", snake_count, 2);
        chk("food1", food_count, 1);

        wr(5, 7, 2'b01);
        chk("ow_snake", snake_count, 1);
        chk("ow_food", food_count, 2);
        wr(6, 7, 2'b10);
        chk("same_snake", snake_count, 1);
        chk("same_food", food_count, 2);
        wr(0, 0, 2'b11);
        look(0, 0);
        chk("q_reserved", q_data, 2'b11);
        chk("res_snake", snake_count, 1);
        chk("res_food", food_count, 2);

        look(2, 2);
        wr_valid = 1'b1; wr_x = 2; wr_y = 2; wr_data = 2'b10;
        #1;
        chk("rdw_old_q", q_data, 2'b00);
        chk("rdw_old_data", data, 2'b00);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("rdw_new_q", q_data, 2'b10);
        chk("rdw_new_data", data, 2'b10);
        chk("rdw_snake", snake_count, 2);

        wr(15, 0, 2'b10);
        chk("err_pulse", wr_err, 1);
        tick();
        chk("err_drop", wr_err, 0);
        chk("err_snake", snake_count, 2);
        chk("err_food", food_count, 2);
        look(15, 0);
        chk("wall_q_x", q_data, 2'b11);
        chk("oor_data_x", data, 2'b00);
        look(0, 15);
        chk("wall_q_y", q_data, 2'b11);
        chk("oor_data_y", data, 2'b00);

        look(1, 1);
        clear_req = 1'b1;
        wr_valid = 1'b1; wr_x = 1; wr_y = 1; wr_data = 2'b10;
        tick();
        clear_req = 1'b0; wr_valid = 1'b0;
        #1;
        chk("clr_busy", busy, 1);
        chk("clr_snake", snake_count, 0);
        chk("clr_food", food_count, 0);
        for (int i = 0; i < 99; i++) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 100;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("clr_len", n, 225);
        look(1, 1);
        chk("clr_cell", q_data, 2'b00);
        all_zero(bad);
        chk("clr_all_zero", bad, 0);
        chk("clr_snake_end", snake_count, 0);

        wr(3, 3, 2'b10);
        chk("pre_rst_snake", snake_count, 1);
        reset = 1'b0;
        #1;
        chk("async_busy", busy, 1);
        chk("async_snake", snake_count, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_x = 4; wr_y = 4; wr_data = 2'b01;
        reset = 1'b1;
        sweep(n, leaks);
        wr_valid = 1'b0;
        chk("rst_sweep_len", n, 225);
        chk("rst_sweep_leaks", leaks, 0);
        look(3, 3);
        chk("rst_cell", data, 2'b00);
        chk("rst_food", food_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snake_grid_buffer.md
Name: snake_grid_buffer

Overview:
- Cell store for the 15x15 snake world: 2 bits per cell, 225 cells, indexed linear as y*15+x.
- Game logic writes cells through a valid/ready port and queries cells for collision checks.
- The display side reads cells combinationally via XLocation/YLocation -> data.
- Runs a clear-sweep state machine after reset and on request, and keeps running counts of snake and food cells.

Parameters:
- GRID_W, 15, cells per row.
- GRID_H, 15, cells per column.
- CELLS, GRID_W*GRID_H (225), total cells and clear-sweep length.

Ports:
- clk  input  1  system clock; same clock as the display controller.
- reset  input  1  asynchronous, active-low reset.
- clear_req  input  1  pulse requesting a full-grid clear.
- busy  output  1  high while the clear sweep runs.
- wr_valid  input  1  write request.
- wr_ready  output  1  write can be accepted this cycle.
- wr_x  input  4  write column.
- wr_y  input  4  write row.
- wr_data  input  2  cell code: 00 world, 01 food, 10 snake, 11 reserved.
- wr_err  output  1  one-cycle pulse after an out-of-range write.
- q_x  input  4  query column.
- q_y  input  4  query row.
- q_data  output  2  query result, combinational.
- XLocation  input  4  display read column.
- YLocation  input  4  display read row.
- data  output  2  display read result, combinational.
- snake_count  output  8  number of cells holding 10.
- food_count  output  8  number of cells holding 01.

Behaviour:
- Storage: 225x2 register array with no reset on the array itself. Reset only forces the FSM into CLEAR.
- FSM states: CLEAR, IDLE.
- Reset asserted (low):
  - state=CLEAR, clr_idx=0, busy=1, wr_ready=0.
  - wr_err=0, snake_count=0, food_count=0.
- CLEAR:
  - Each cycle write 00 to mem[clr_idx] and increment clr_idx.
  - On the cycle with clr_idx=224 the final write occurs; next state is IDLE.
  - Total 225 cycles from reset release to busy=0.
- CLEAR side rules:
  - wr_ready=0 and busy=1.
  - clear_req is ignored.
  - data forced to 00; q_data forced to 00.
- IDLE:
  - busy=0; wr_ready=1 (combinational, state==IDLE).
  - Write is accepted on any edge where wr_valid&&wr_ready.
- In-range accepted write (wr_x<15 and wr_y<15):
  - mem[wr_y*15+wr_x] <= wr_data.
  - Counters update on the same edge using the old value read that cycle:
    - Decrement the counter for the old code (if 01 or 10).
    - Increment the counter for the new code (if 01 or 10).
  - Same old and new code: no net change. Code 11 counts toward neither counter.
- Out-of-range accepted write (wr_x>=15 or wr_y>=15):
  - No memory or counter change.
  - wr_err=1 for exactly the next cycle, otherwise 0.
- clear_req while IDLE:
  - Next state CLEAR, clr_idx<=0, snake_count<=0 and food_count<=0 on that edge.
  - A write accepted on that same edge is performed, then wiped by the sweep; counters still end at 0.
- Display read:
  - data = 00 if state==CLEAR or XLocation>=15 or YLocation>=15.
  - Otherwise data = mem[YLocation*15+XLocation].
  - Zero-latency combinational; the controller samples it on its own registered edge.
- Query read:
  - q_data = 11 (wall) if q_x>=15 or q_y>=15.
  - Otherwise q_data = mem[q_y*15+q_x], with 00 forced during CLEAR.
- Read during write to the same cell: both reads return the old value until the write edge, and the new value from the following cycle.
- Width rules:
  - Index arithmetic is 8 bits: y*15 max 210, plus x gives max 224.
  - Counters are 8 bits and cannot exceed 225, so no wrap.
- Reset mid-sweep or mid-write: immediately returns to CLEAR with clr_idx=0; any partial state is discarded.

Test Plan:
- Release reset, count cycles until busy falls -> busy=0 exactly 225 cycles after release. During the sweep data=00 for XLocation=3,YLocation=4. Afterwards every cell reads 00 and both counts are 0.
- Write (x=5,y=7,10), then (x=6,y=7,10), then (x=14,y=14,01) -> q_data at (5,7)=10; data at (14,14)=01; snake_count=2, food_count=1.
- Overwrite (5,7) with 01, then write (6,7) with 10 again -> snake_count=1, food_count=2. The repeated write leaves counts unchanged.
- Write x=15,y=0 with 10 -> wr_err high exactly one cycle, counts unchanged. q_x=15 -> q_data=11; XLocation=15 -> data=00.
- clear_req together with wr_valid (x=1,y=1,10) -> write accepted, busy=1 next cycle, counts 0. After 225 cycles (1,1) reads 00. A clear_req pulse mid-sweep does not restart it.
- Drop reset low during the sweep at clr_idx≈100 and release -> the full 225-cycle sweep restarts and wr_ready stays 0 throughout.
